// File: rtl/lcd_screen_scheduler.sv
// Chooses the picture code shown on the LCD; every change is taken on a frame_done pulse.
// Build option: define SCHED_SLEEP_ANIM_EN to alternate the open/closed sleep pictures.
module lcd_screen_scheduler #(
    parameter int BOOT_FRAMES  = 8,
    parameter int DWELL_FRAMES = 4,
    parameter int ANIM_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic       req_eat,
    input  logic       req_heal,
    input  logic       req_play,
    input  logic       sleeping,
    input  logic       dead,
    output logic [2:0] estado,
    output logic       action_ack,
    output logic       busy,
    output logic [2:0] pending
);
    localparam int MAX_BD = (BOOT_FRAMES > DWELL_FRAMES) ? BOOT_FRAMES : DWELL_FRAMES;
    localparam int MAX_P  = (MAX_BD > ANIM_FRAMES) ? MAX_BD : ANIM_FRAMES;
    localparam int CW     = $clog2(MAX_P) + 1;

    // A zero parameter still needs one pulse to leave the state.
    localparam logic [CW-1:0] BOOT_N  = CW'((BOOT_FRAMES == 0) ? 1 : BOOT_FRAMES);
    localparam logic [CW-1:0] DWELL_N = CW'((DWELL_FRAMES == 0) ? 1 : DWELL_FRAMES);
`ifdef SCHED_SLEEP_ANIM_EN
    localparam logic [CW-1:0] ANIM_N  = CW'((ANIM_FRAMES == 0) ? 1 : ANIM_FRAMES);
`endif

    localparam logic [2:0] PIC_BOOT         = 3'b000;
    localparam logic [2:0] PIC_SLEEP_OPEN   = 3'b001;
    localparam logic [2:0] PIC_SMILE        = 3'b010;
    localparam logic [2:0] PIC_APPLE        = 3'b011;
    localparam logic [2:0] PIC_SLEEP_CLOSED = 3'b100;
    localparam logic [2:0] PIC_CROSS        = 3'b101;
    localparam logic [2:0] PIC_BALL         = 3'b110;
    localparam logic [2:0] PIC_RIP          = 3'b111;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_ACTION,
        S_SLEEP_A,
`ifdef SCHED_SLEEP_ANIM_EN
        S_SLEEP_B,
`endif
        S_DEAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]      estado_q, estado_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [2:0]      pending_q, pending_d;
    logic [2:0]      pend_set, serve_bit, serve_code;
    logic            leave;

    always_comb begin
        // NOTE: every value driven here is defaulted first, so no branch can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        ack_d      = 1'b0;
        leave      = 1'b0;
        cnt_inc    = cnt_q + CW'(1);
        pend_set   = pending_q | {req_heal, req_eat, req_play};
        serve_bit  = 3'b000;
        serve_code = PIC_SMILE;

        if (pend_set[2]) begin
            serve_bit  = 3'b100;
            serve_code = PIC_CROSS;
        end else if (pend_set[1]) begin
            serve_bit  = 3'b010;
            serve_code = PIC_APPLE;
        end else if (pend_set[0]) begin
            serve_bit  = 3'b001;
            serve_code = PIC_BALL;
        end

        if (state_q != S_DEAD) begin
            pending_d = pend_set;
        end

        if (frame_done && state_q != S_DEAD) begin
            cnt_d = cnt_inc;
            case (state_q)
                S_BOOT:   if (cnt_inc == BOOT_N) state_d = S_IDLE;
                S_IDLE:   leave = 1'b1;
                S_ACTION: if (cnt_inc == DWELL_N) leave = 1'b1;
                S_SLEEP_A: begin
                    if (!sleeping) state_d = S_IDLE;
`ifdef SCHED_SLEEP_ANIM_EN
                    else if (cnt_inc == ANIM_N) state_d = S_SLEEP_B;
`endif
                end
`ifdef SCHED_SLEEP_ANIM_EN
                S_SLEEP_B: begin
                    if (!sleeping) state_d = S_IDLE;
                    else if (cnt_inc == ANIM_N) state_d = S_SLEEP_A;
                end
`endif
                default: ;
            endcase

            // Death overrides everything, including an unfinished dwell.
            if (dead) begin
                state_d   = S_DEAD;
                pending_d = 3'b000;
            end else if (leave) begin
                if (|pend_set) begin
                    state_d   = S_ACTION;
                    pending_d = pend_set & ~serve_bit;
                    ack_d     = 1'b1;
                end else if (sleeping) begin
                    state_d = S_SLEEP_A;
                end else begin
                    state_d = S_IDLE;
                end
            end

            // A chained action restarts the dwell even though the state is unchanged.
            if (state_d != state_q || ack_d || state_d == S_IDLE) begin
                cnt_d = '0;
            end
        end

        busy_d = (state_d == S_ACTION);
        case (state_d)
            S_BOOT:    estado_d = PIC_BOOT;
            S_IDLE:    estado_d = PIC_SMILE;
            S_ACTION:  estado_d = ack_d ? serve_code : estado_q;
            S_SLEEP_A: estado_d = PIC_SLEEP_OPEN;
`ifdef SCHED_SLEEP_ANIM_EN
            S_SLEEP_B: estado_d = PIC_SLEEP_CLOSED;
`endif
            S_DEAD:    estado_d = PIC_RIP;
            default:   estado_d = PIC_BOOT;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_BOOT;
            cnt_q     <= '0;
            estado_q  <= PIC_BOOT;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            estado_q  <= estado_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign estado     = estado_q;
    assign action_ack = ack_q;
    assign busy       = busy_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_lcd_screen_scheduler.sv
// Directed bench for lcd_screen_scheduler: a frame-level screen model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_lcd_screen_scheduler;
    localparam int BOOT_FRAMES  = 8;
    localparam int DWELL_FRAMES = 4;
    localparam int ANIM_FRAMES  = 2;

`ifdef SCHED_SLEEP_ANIM_EN
    localparam logic [2:0] SLP_B = 3'b100;
`else
    localparam logic [2:0] SLP_B = 3'b001;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_done = 1'b0;
    logic       req_eat = 1'b0, req_heal = 1'b0, req_play = 1'b0;
    logic       sleeping = 1'b0, dead = 1'b0;
    logic [2:0] estado, pending;
    logic       action_ack, busy;

    int n_checks = 0;
    int n_errors = 0;
    int ack_seen = 0;
    int ack_base = 0;

    always #5 clk = ~clk;

    lcd_screen_scheduler #(
        .BOOT_FRAMES (BOOT_FRAMES),
        .DWELL_FRAMES(DWELL_FRAMES),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_done(frame_done),
        .req_eat   (req_eat),
        .req_heal  (req_heal),
        .req_play  (req_play),
        .sleeping  (sleeping),
        .dead      (dead),
        .estado    (estado),
        .action_ack(action_ack),
        .busy      (busy),
        .pending   (pending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Screen model: a mode, a countdown of frames left, and three pending flags.
    localparam int M_BOOT = 0, M_IDLE = 1, M_ACT = 2, M_SLEEP = 3, M_DEAD = 4;
    int         m_mode   = M_BOOT;
    int         m_left   = BOOT_FRAMES;
    int         m_code   = 0;
    bit         m_closed = 1'b0;
    bit [2:0]   m_pend   = 3'b000;
    bit         m_ack    = 1'b0;

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic logic [2:0] m_estado();
        case (m_mode)
            M_BOOT:  return 3'd0;
            M_IDLE:  return 3'd2;
            M_ACT:   return 3'(m_code);
            M_SLEEP: return m_closed ? 3'd4 : 3'd1;
            default: return 3'd7;
        endcase
    endfunction

    task automatic m_choose();
        if (m_pend != 3'b000) begin
            m_mode = M_ACT;
            m_left = eff(DWELL_FRAMES);
            m_ack  = 1'b1;
            if (m_pend[2]) begin
                m_code = 5; m_pend[2] = 1'b0;
            end else if (m_pend[1]) begin
                m_code = 3; m_pend[1] = 1'b0;
            end else begin
                m_code = 6; m_pend[0] = 1'b0;
            end
        end else if (sleeping) begin
            m_mode   = M_SLEEP;
            m_closed = 1'b0;
            m_left   = eff(ANIM_FRAMES);
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_mode = M_BOOT; m_left = eff(BOOT_FRAMES); m_pend = 3'b000;
            m_ack = 1'b0; m_closed = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (m_mode != M_DEAD) m_pend = m_pend | {req_heal, req_eat, req_play};
            if (frame_done && m_mode != M_DEAD) begin
                if (dead) begin
                    m_mode = M_DEAD;
                    m_pend = 3'b000;
                end else begin
                    case (m_mode)
                        M_BOOT: begin
                            m_left = m_left - 1;
                            if (m_left == 0) m_mode = M_IDLE;
                        end
                        M_IDLE: m_choose();
                        M_ACT: begin
                            m_left = m_left - 1;
                            if (m_left == 0) m_choose();
                        end
                        M_SLEEP: begin
                            if (!sleeping) m_mode = M_IDLE;
`ifdef SCHED_SLEEP_ANIM_EN
                            else begin
                                m_left = m_left - 1;
                                if (m_left == 0) begin
                                    m_closed = !m_closed;
                                    m_left   = eff(ANIM_FRAMES);
                                end
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Cycle compare on the falling edge, away from the edge the DUT samples on.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("estado", estado, m_estado());
            check("action_ack", action_ack, m_ack);
            check("busy", busy, m_mode == M_ACT);
            check("pending", pending, m_pend);
            if (action_ack) ack_seen++;
        end
    end

    task automatic frame();
        repeat (2) @(posedge clk);
        @(posedge clk); #2 frame_done = 1'b1;
        @(posedge clk); #2 frame_done = 1'b0;
    endtask

    task automatic frame_with_req(input logic [2:0] r);
        repeat (2) @(posedge clk);
        @(posedge clk); #2 frame_done = 1'b1; {req_heal, req_eat, req_play} = r;
        @(posedge clk); #2 frame_done = 1'b0; {req_heal, req_eat, req_play} = 3'b000;
    endtask

    task automatic req(input logic [2:0] r);
        @(posedge clk); #2 {req_heal, req_eat, req_play} = r;
        @(posedge clk); #2 {req_heal, req_eat, req_play} = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        #3;
        check("reset_estado", estado, 3'b000);
        check("reset_busy", busy, 1'b0);
        check("reset_ack", action_ack, 1'b0);
        check("reset_pending", pending, 3'b000);
        @(posedge clk); #2 rst = 1'b1;

        // Boot picture for eight frames, smile right after the eighth.
        repeat (7) frame();
        check("boot_hold", estado, 3'b000);
        frame();
        check("boot_end", estado, 3'b010);
        check("boot_pending", pending, 3'b000);

        // Play, heal, duplicate play: cross, ball, then a re-requested ball.
        ack_base = ack_seen;
        req(3'b001); req(3'b100); req(3'b001);
        check("merged_pending", pending, 3'b101);
        frame();
        check("cross_start", estado, 3'b101);
        check("cross_ack", action_ack, 1'b1);
        check("cross_busy", busy, 1'b1);
        check("cross_pending", pending, 3'b001);
        for (int i = 0; i < 3; i++) begin
            frame();
            check("cross_hold", estado, 3'b101);
        end
        frame();
        check("ball_start", estado, 3'b110);
        check("ball_ack", action_ack, 1'b1);
        check("ball_pending", pending, 3'b000);
        req(3'b001);
        check("ball_rereq", pending, 3'b001);
        for (int i = 0; i < 3; i++) frame();
        frame();
        check("ball_again", estado, 3'b110);
        check("ball_again_ack", action_ack, 1'b1);
        for (int i = 0; i < 4; i++) frame();
        check("actions_idle", estado, 3'b010);
        check("actions_busy", busy, 1'b0);
        check("ack_count", ack_seen - ack_base, 3);

        // Sleep animation, then wake-up during the second picture.
        #1 sleeping = 1'b1;
        frame(); check("sleep_f1", estado, 3'b001);
        frame(); check("sleep_f2", estado, 3'b001);
        frame(); check("sleep_f3", estado, SLP_B);
        frame(); check("sleep_f4", estado, SLP_B);
        #1 sleeping = 1'b0;
        frame(); check("wake_idle", estado, 3'b010);

        // Eat request while asleep is held until after wake-up.
        #1 sleeping = 1'b1;
        frame(); check("sleep2_f1", estado, 3'b001);
        req(3'b010);
        check("sleep_pending", pending, 3'b010);
        frame(); check("sleep2_f2", estado, 3'b001);
        frame(); check("sleep2_f3", estado, SLP_B);
        check("sleep_pending_held", pending, 3'b010);
        #1 sleeping = 1'b0;
        frame(); check("wake2_idle", estado, 3'b010);
        frame(); check("apple_after_wake", estado, 3'b011);
        check("apple_pending", pending, 3'b000);

        // Asynchronous reset in the middle of a dwell.
        req(3'b001);
        check("pre_reset_pending", pending, 3'b001);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        check("async_estado", estado, 3'b000);
        check("async_busy", busy, 1'b0);
        check("async_pending", pending, 3'b000);
        @(posedge clk); #2 rst = 1'b1;
        repeat (8) frame();
        check("reboot_idle", estado, 3'b010);

        // Request in the same cycle as frame_done, then death mid-action.
        frame_with_req(3'b010);
        check("same_cycle_apple", estado, 3'b011);
        check("same_cycle_ack", action_ack, 1'b1);
        frame();
        req(3'b001);
        #1 dead = 1'b1;
        frame();
        check("dead_estado", estado, 3'b111);
        check("dead_busy", busy, 1'b0);
        check("dead_pending", pending, 3'b000);
        req(3'b100);
        check("dead_ignore", pending, 3'b000);
        frame_with_req(3'b111);
        check("dead_terminal", estado, 3'b111);
        check("dead_ignore2", pending, 3'b000);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
